// File: rtl/axicb_resp_router.sv
// ============================================================================
// Module      : axicb_resp_router
// Description : Return-path router for the crossbar arbiter. Records each
//               accepted grant in order and steers in-order response bursts
//               back to the requester that issued them.
//               Optional macro AXICB_ORPHAN_DROP_EN: accept and drop responses
//               that arrive with nothing outstanding, flagging orphan_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axicb_resp_router #(
    parameter int REQ_NB  = 4,
    parameter int OSTD_NB = 4,
    parameter int DATA_W  = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           srst,
    input  logic                           req_valid,
    input  logic [REQ_NB-1:0]              req_grant,
    input  logic                           req_ready_in,
    output logic                           req_ready,
    input  logic                           s_rvalid,
    output logic                           s_rready,
    input  logic                           s_rlast,
    input  logic [DATA_W-1:0]              s_rdata,
    output logic [REQ_NB-1:0]              m_rvalid,
    input  logic [REQ_NB-1:0]              m_rready,
    output logic                           m_rlast,
    output logic [DATA_W-1:0]              m_rdata,
    output logic [$clog2(OSTD_NB+1)-1:0]   outstanding
`ifdef AXICB_ORPHAN_DROP_EN
    ,
    output logic                           orphan_err
`endif
);

    localparam int IDX_W = $clog2(OSTD_NB);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(OSTD_NB + 1);

    logic [REQ_NB-1:0] mem_q [OSTD_NB];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  outstanding_q;

    logic              w_rst_act;
    logic              w_empty;
    logic              w_full;
    logic [REQ_NB-1:0] w_head;
    logic              w_route_rdy;
    logic              w_push;
    logic              w_pop;

    assign w_rst_act = !aresetn || srst;

    // Extra pointer MSB separates the full case from the empty case.
    assign w_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                     (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);

    assign w_head      = w_empty ? '0 : mem_q[rptr_q[IDX_W-1:0]];
    assign w_route_rdy = |(w_head & m_rready);

    assign req_ready = req_ready_in && (w_rst_act || !w_full);
    assign w_push    = req_valid && req_ready && (|req_grant) && !w_rst_act;

    assign m_rvalid = w_rst_act ? '0 : (w_head & {REQ_NB{s_rvalid}});
    assign m_rdata  = s_rdata;
    assign m_rlast  = s_rlast;

`ifdef AXICB_ORPHAN_DROP_EN
    assign s_rready = !w_rst_act && (w_route_rdy || w_empty);
`else
    assign s_rready = !w_rst_act && w_route_rdy;
`endif

    // Orphan beats (empty FIFO) never pop.
    assign w_pop = s_rvalid && s_rready && s_rlast && !w_empty;

    assign wptr_d = wptr_q + PTR_W'(w_push);
    assign rptr_d = rptr_q + PTR_W'(w_pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            outstanding_q <= '0;
        end else if (srst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            outstanding_q <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            outstanding_q <= CNT_W'(wptr_d - rptr_d);
        end
    end

    // Entry contents are only read when valid, so storage needs no reset.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            mem_q[wptr_q[IDX_W-1:0]] <= req_grant;
        end
    end

    assign outstanding = outstanding_q;

`ifdef AXICB_ORPHAN_DROP_EN
    logic orphan_err_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            orphan_err_q <= 1'b0;
        end else if (srst) begin
            orphan_err_q <= 1'b0;
        end else if (s_rvalid && w_empty) begin
            orphan_err_q <= 1'b1;
        end
    end

    assign orphan_err = orphan_err_q;
`endif

    a_grant_onehot : assert property (@(posedge aclk) disable iff (!aresetn)
        (req_valid && req_ready && (|req_grant)) |-> $onehot(req_grant));

endmodule

`default_nettype wire

// File: tb/tb_axicb_resp_router.sv
// ============================================================================
// Module      : tb_axicb_resp_router
// Description : Self-checking bench for axicb_resp_router against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axicb_resp_router;

    localparam int REQ_NB  = 4;
    localparam int OSTD_NB = 4;
    localparam int DATA_W  = 8;
`ifdef AXICB_ORPHAN_DROP_EN
    localparam bit ORPH = 1'b1;
`else
    localparam bit ORPH = 1'b0;
`endif

    logic              aclk = 1'b0;
    logic              aresetn, srst;
    logic              req_valid, req_ready_in, req_ready;
    logic [REQ_NB-1:0] req_grant;
    logic              s_rvalid, s_rready, s_rlast;
    logic [DATA_W-1:0] s_rdata, m_rdata;
    logic [REQ_NB-1:0] m_rvalid, m_rready;
    logic              m_rlast;
    logic [2:0]        outstanding;
`ifdef AXICB_ORPHAN_DROP_EN
    logic              orphan_err;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Reference model: queue of outstanding grants, oldest first.
    logic [REQ_NB-1:0] q[$];
    bit                m_orph = 1'b0;

    axicb_resp_router #(.REQ_NB(REQ_NB), .OSTD_NB(OSTD_NB), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .req_valid(req_valid), .req_grant(req_grant), .req_ready_in(req_ready_in),
        .req_ready(req_ready),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast), .s_rdata(s_rdata),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
        .outstanding(outstanding)
`ifdef AXICB_ORPHAN_DROP_EN
        , .orphan_err(orphan_err)
`endif
    );

    always #5 aclk = ~aclk;

    function automatic logic [REQ_NB-1:0] onehot_rand();
        logic [REQ_NB-1:0] v;
        v = '0;
        v[$urandom_range(REQ_NB-1, 0)] = 1'b1;
        return v;
    endfunction

    function automatic logic [REQ_NB-1:0] mdl_head();
        return (q.size() == 0) ? '0 : q[0];
    endfunction

    task automatic idle();
        srst = 0; req_valid = 0; req_grant = '0; req_ready_in = 1;
        s_rvalid = 0; s_rlast = 0; s_rdata = '0; m_rready = '0;
    endtask

    // Advance one clock edge and apply the spec rules to the model.
    task automatic tick();
        bit empty, full, push, pop;
        logic [REQ_NB-1:0] head;
        @(posedge aclk);
        empty = (q.size() == 0);
        full  = (q.size() == OSTD_NB);
        head  = mdl_head();
        push  = req_valid && req_ready_in && !full && (req_grant != 0);
        pop   = s_rvalid && s_rlast && ((head & m_rready) != 0);
        if (!aresetn || srst) begin
            q.delete();
            m_orph = 1'b0;
        end else begin
            if (s_rvalid && empty) m_orph = 1'b1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(req_grant);
        end
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        idle();
        m_rready = '1; s_rvalid = 1; s_rlast = 1;
        while (q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        n_chk++;
        if (q.size() != 0 || outstanding !== 3'd0) begin
            n_err++;
            $display("FAIL drain_timeout outstanding=%0d expected=0", outstanding);
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        aresetn = 0; s_rvalid = 1; m_rready = '1; req_valid = 1; req_grant = 4'b0001;
        #2;
        n_chk++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL rst_mrvalid got=%b exp=0000", m_rvalid); end
        n_chk++; if (s_rready !== 1'b0) begin n_err++; $display("FAIL rst_srready got=%b exp=0", s_rready); end
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_reqready got=%b exp=1", req_ready); end
        req_ready_in = 0; #1;
        n_chk++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_reqready_pass got=%b exp=0", req_ready); end
        n_chk++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
        tick(); tick();
        idle();
        aresetn = 1;
        tick();
        n_chk++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rst_post_outstanding got=%0d exp=0", outstanding); end
`ifdef AXICB_ORPHAN_DROP_EN
        n_chk++; if (orphan_err !== 1'b0) begin n_err++; $display("FAIL rst_orphan_err got=%b exp=0", orphan_err); end
`endif
    endtask

    task automatic test_single_read();
        idle();
        req_valid = 1; req_grant = 4'b0100; s_rvalid = 1; s_rlast = 1; s_rdata = 8'h5A; m_rready = '1;
        @(negedge aclk);
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL single_reqready got=%b exp=1", req_ready); end
        n_chk++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL single_nobypass_mrvalid got=%b exp=0000", m_rvalid); end
        n_chk++; if (s_rready !== ORPH) begin n_err++; $display("FAIL single_nobypass_srready got=%b exp=%b", s_rready, ORPH); end
        tick();
        req_valid = 0; req_grant = '0; m_rready = 4'b0100;
        @(negedge aclk);
        n_chk++; if (m_rvalid !== 4'b0100) begin n_err++; $display("FAIL single_mrvalid got=%b exp=0100", m_rvalid); end
        n_chk++; if (m_rdata !== 8'h5A) begin n_err++; $display("FAIL single_mrdata got=%h exp=5a", m_rdata); end
        n_chk++; if (m_rlast !== 1'b1) begin n_err++; $display("FAIL single_mrlast got=%b exp=1", m_rlast); end
        n_chk++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL single_out1 got=%0d exp=1", outstanding); end
        tick();
        idle();
        @(negedge aclk);
        n_chk++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL single_out0 got=%0d exp=0", outstanding); end
    endtask

    task automatic test_ordering();
        logic [REQ_NB-1:0] g[3];
        logic [DATA_W-1:0] d;
        g[0] = 4'b0001; g[1] = 4'b1000; g[2] = 4'b0010;
        idle();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1; req_grant = g[i];
            tick();
        end
        idle();
        m_rready = '1; s_rvalid = 1;
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 2; b++) begin
                d = DATA_W'($urandom);
                s_rdata = d; s_rlast = (b == 1);
                @(negedge aclk);
                n_chk++; if (m_rvalid !== g[i]) begin n_err++; $display("FAIL order_mrvalid burst=%0d beat=%0d got=%b exp=%b", i, b, m_rvalid, g[i]); end
                n_chk++; if (m_rdata !== d) begin n_err++; $display("FAIL order_mrdata got=%h exp=%h", m_rdata, d); end
                n_chk++; if (outstanding !== 3'(3 - i)) begin n_err++; $display("FAIL order_outstanding got=%0d exp=%0d", outstanding, 3 - i); end
                tick();
            end
        end
        idle();
        @(negedge aclk);
        n_chk++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL order_final got=%0d exp=0", outstanding); end
    endtask

    task automatic test_full();
        idle();
        for (int i = 0; i < OSTD_NB; i++) begin
            req_valid = 1; req_grant = onehot_rand();
            tick();
        end
        req_grant = 4'b0001;
        @(negedge aclk);
        n_chk++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_outstanding got=%0d exp=4", outstanding); end
        n_chk++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_reqready got=%b exp=0", req_ready); end
        tick();
        s_rvalid = 1; s_rlast = 1; m_rready = '1;
        @(negedge aclk);
        n_chk++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_nopush got=%0d exp=4", outstanding); end
        n_chk++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_reqready got=%b exp=0", req_ready); end
        tick();
        s_rvalid = 0; req_valid = 0;
        @(negedge aclk);
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_after_pop_reqready got=%b exp=1", req_ready); end
        n_chk++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL full_after_pop_out got=%0d exp=3", outstanding); end
        tick();
        drain();
    endtask

    task automatic test_backpressure();
        idle();
        req_valid = 1; req_grant = 4'b0010;
        tick();
        idle();
        s_rvalid = 1; s_rlast = 1; m_rready = 4'b1101;
        @(negedge aclk);
        n_chk++; if (s_rready !== 1'b0) begin n_err++; $display("FAIL bp_srready_low got=%b exp=0", s_rready); end
        n_chk++; if (m_rvalid !== 4'b0010) begin n_err++; $display("FAIL bp_mrvalid got=%b exp=0010", m_rvalid); end
        tick();
        @(negedge aclk);
        n_chk++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL bp_held got=%0d exp=1", outstanding); end
        m_rready = 4'b1111;
        #1;
        n_chk++; if (s_rready !== 1'b1) begin n_err++; $display("FAIL bp_srready_high got=%b exp=1", s_rready); end
        tick();
        idle();
        @(negedge aclk);
        n_chk++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL bp_popped got=%0d exp=0", outstanding); end
    endtask

    task automatic test_simul_push_pop();
        idle();
        for (int i = 0; i < 2; i++) begin
            req_valid = 1; req_grant = onehot_rand();
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            req_valid = 1; req_grant = onehot_rand();
            s_rvalid = 1; s_rlast = 1; m_rready = '1;
            @(negedge aclk);
            n_chk++; if (m_rvalid !== mdl_head()) begin n_err++; $display("FAIL pp_mrvalid iter=%0d got=%b exp=%b", i, m_rvalid, mdl_head()); end
            n_chk++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL pp_outstanding iter=%0d got=%0d exp=2", i, outstanding); end
            tick();
        end
        drain();
    endtask

    task automatic test_srst();
        idle();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1; req_grant = onehot_rand();
            tick();
        end
        idle();
        srst = 1; s_rvalid = 1; s_rlast = 0; m_rready = '1; req_valid = 1; req_grant = 4'b0001;
        @(negedge aclk);
        n_chk++; if (s_rready !== 1'b0) begin n_err++; $display("FAIL srst_srready got=%b exp=0", s_rready); end
        n_chk++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL srst_mrvalid got=%b exp=0000", m_rvalid); end
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL srst_reqready got=%b exp=1", req_ready); end
        tick();
        idle();
        @(negedge aclk);
        n_chk++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL srst_outstanding got=%0d exp=0", outstanding); end
        n_chk++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL srst_post_mrvalid got=%b exp=0000", m_rvalid); end
        tick();
    endtask

    task automatic test_orphan();
        idle();
        srst = 1; tick(); idle();
        s_rvalid = 1; s_rlast = 1; m_rready = '1;
        @(negedge aclk);
        n_chk++; if (s_rready !== ORPH) begin n_err++; $display("FAIL orphan_srready got=%b exp=%b", s_rready, ORPH); end
        n_chk++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL orphan_mrvalid got=%b exp=0000", m_rvalid); end
`ifdef AXICB_ORPHAN_DROP_EN
        n_chk++; if (orphan_err !== 1'b0) begin n_err++; $display("FAIL orphan_err_pre got=%b exp=0", orphan_err); end
        tick();
        s_rvalid = 0;
        @(negedge aclk);
        n_chk++; if (orphan_err !== 1'b1) begin n_err++; $display("FAIL orphan_err_set got=%b exp=1", orphan_err); end
        tick(); tick();
        n_chk++; if (orphan_err !== 1'b1) begin n_err++; $display("FAIL orphan_err_sticky got=%b exp=1", orphan_err); end
        srst = 1; tick(); srst = 0;
        n_chk++; if (orphan_err !== 1'b0) begin n_err++; $display("FAIL orphan_err_clr got=%b exp=0", orphan_err); end
`else
        tick();
`endif
        idle();
        tick();
    endtask

    task automatic test_random();
        bit                exp_rr, exp_sr;
        logic [REQ_NB-1:0] exp_mv, head;
        for (int c = 0; c < 400; c++) begin
            srst         = ($urandom_range(59, 0) == 0);
            req_valid    = $urandom_range(1, 0) == 1;
            req_grant    = ($urandom_range(4, 0) == 0) ? '0 : onehot_rand();
            req_ready_in = $urandom_range(3, 0) != 0;
            s_rvalid     = $urandom_range(1, 0) == 1;
            s_rlast      = $urandom_range(1, 0) == 1;
            s_rdata      = DATA_W'($urandom);
            m_rready     = REQ_NB'($urandom);
            @(negedge aclk);
            head   = mdl_head();
            exp_rr = req_ready_in && (srst || q.size() < OSTD_NB);
            exp_mv = srst ? '0 : (head & {REQ_NB{s_rvalid}});
            exp_sr = !srst && (((head & m_rready) != 0) || (ORPH && q.size() == 0));
            n_chk++; if (req_ready !== exp_rr) begin n_err++; $display("FAIL rnd_reqready cyc=%0d got=%b exp=%b", c, req_ready, exp_rr); end
            n_chk++; if (m_rvalid !== exp_mv) begin n_err++; $display("FAIL rnd_mrvalid cyc=%0d got=%b exp=%b", c, m_rvalid, exp_mv); end
            n_chk++; if (s_rready !== exp_sr) begin n_err++; $display("FAIL rnd_srready cyc=%0d got=%b exp=%b", c, s_rready, exp_sr); end
            n_chk++; if (outstanding !== 3'(q.size())) begin n_err++; $display("FAIL rnd_outstanding cyc=%0d got=%0d exp=%0d", c, outstanding, q.size()); end
            n_chk++; if (m_rdata !== s_rdata || m_rlast !== s_rlast) begin n_err++; $display("FAIL rnd_copy cyc=%0d got=%h/%b exp=%h/%b", c, m_rdata, m_rlast, s_rdata, s_rlast); end
`ifdef AXICB_ORPHAN_DROP_EN
            n_chk++; if (orphan_err !== m_orph) begin n_err++; $display("FAIL rnd_orphan_err cyc=%0d got=%b exp=%b", c, orphan_err, m_orph); end
`endif
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_ordering();
        test_full();
        test_backpressure();
        test_simul_push_pop();
        test_srst();
        test_orphan();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/axicb_resp_router.md
Name: axicb_resp_router

Overview:
- Return-path companion to the crossbar round-robin arbiter.
- Records, in arbitration order, which requester won each accepted request.
- Routes the slave's response beats back to the matching requester; pops the record on the last beat.
- Sits between the merged slave-side response channel and the N master-side response channels; in-order responses only.

Parameters:
REQ_NB, 4, number of requesters; supported values are 4 or 8.
OSTD_NB, 4, maximum outstanding requests; power of 2, at least 2.
DATA_W, 8, response payload width.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
srst  in  1  synchronous reset, active high
req_valid  in  1  merged request valid, after the arbiter
req_grant  in  REQ_NB  one-hot arbiter grant for the current request
req_ready_in  in  1  downstream slave ready for the request
req_ready  out  1  request ready returned to the arbiter/master side
s_rvalid  in  1  slave response valid
s_rready  out  1  slave response ready
s_rlast  in  1  last beat of the response
s_rdata  in  DATA_W  response payload
m_rvalid  out  REQ_NB  per-requester response valid
m_rready  in  REQ_NB  per-requester response ready
m_rlast  out  1  broadcast copy of s_rlast
m_rdata  out  DATA_W  broadcast copy of s_rdata
outstanding  out  $clog2(OSTD_NB+1)  number of occupied FIFO entries

Behaviour:
- Reset (aresetn low, async, or srst high at a clock edge):
  - read/write pointers cleared; outstanding = 0; FIFO empty.
  - Outputs during reset: m_rvalid = 0, s_rready = 0, req_ready = req_ready_in.
- Ordering FIFO: OSTD_NB entries, each REQ_NB wide, storing the one-hot grant.
  - Pointers are $clog2(OSTD_NB)+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2*OSTD_NB.
- Push: when req_valid & req_ready & |req_grant, write req_grant at wptr, then wptr+1.
  - req_valid with req_grant = 0: pass-through only, no push.
- req_ready = req_ready_in & !full. Combinational; no extra latency on the request path.
- Head = FIFO entry at rptr when not empty; otherwise 0.
- Routing:
  - m_rvalid = head & {REQ_NB{s_rvalid}}.
  - s_rready = |(head & m_rready).
  - m_rdata and m_rlast are direct copies of s_rdata and s_rlast.
- Pop: when s_rvalid & s_rready & s_rlast, rptr+1. Non-last beats do not pop; a burst stays locked to one requester.
- Latency: an entry pushed in cycle N can route a response from cycle N+1. No same-cycle bypass into an empty FIFO.
- FIFO empty: s_rready = 0 and m_rvalid = 0. The response stalls, unless the optional feature is enabled.
- Push and pop in the same cycle: both take effect; outstanding is unchanged.
- Full and pop in the same cycle: req_ready remains 0 that cycle (no look-ahead). The push becomes possible the next cycle.
- outstanding = wptr - rptr, registered; it is not a counter, so it is always consistent with the pointers.
- srst asserted mid-burst: all tracking entries are dropped and the current beat is not acknowledged. The system must quiesce before srst.
- Stored grants are trusted one-hot; a multi-hot grant is undefined behaviour and is caught by an assertion in simulation.

Optional Feature:
- Macro: AXICB_ORPHAN_DROP_EN.
- Enabled:
  - s_rvalid with an empty FIFO is accepted (s_rready = 1) and dropped; no m_rvalid is asserted.
  - An extra output port, orphan_err (1 bit), sets on the first dropped beat.
  - orphan_err is sticky and cleared only by aresetn or srst.
- Disabled: orphan responses stall as described above, and the orphan_err port does not exist.

Test Plan:
- Single read: push grant 4'b0100, then a 1-beat response with rdata 0x5A one cycle later -> m_rvalid = 4'b0100, m_rdata = 0x5A, outstanding 1 -> 0 after the handshake.
- Ordering: push grants 0001, 1000, 0010, then three 2-beat bursts -> beats arrive on req 0, 3, 1 in that order; no pop on non-last beats.
- Full: push 4 grants with no response -> outstanding = 4, req_ready = 0 even with req_ready_in = 1; one pop -> req_ready = 1 on the next cycle.
- Backpressure: head = 0010, m_rready = 4'b1101 -> s_rready = 0 and the beat is held; raise m_rready[1] -> accepted, then popped on rlast.
- Simultaneous push/pop at outstanding = 2 -> outstanding stays 2 and the pointers wrap correctly over 10 iterations.
- Reset mid-operation: srst with 3 outstanding -> outstanding = 0, m_rvalid = 0.
  - Orphan beat with the macro enabled -> accepted and orphan_err = 1.
  - Orphan beat with the macro disabled -> s_rready = 0.
